// File: rtl/muldiv_seq.sv
// muldiv_seq - iterative multiply/divide unit holding the architectural HI/LO pair.
// Computes one result bit per clock: LSB-first shift-add multiply or restoring divide,
// finishing WIDTH edges after the start edge. A divide by zero skips iteration and
// completes on the start edge itself.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : op_signed selects signed (mult/div) or unsigned (multu/divu) operation;
//               magnitude conversion and result sign fixup are built.
//   undefined : op_signed is ignored, every operation is unsigned, no negation logic.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               launch an operation (accepted in IDLE or DONE only)
//   mul0_div1_sel       0 = multiply, 1 = divide
//   op_signed           signed operation request (honoured only with MULDIV_SIGNED_EN)
//   a, b                multiplicand/dividend, multiplier/divisor
//   hilo_we             mthi/mtlo write strobe (ignored while busy)
//   hi0_lo1_sel         write target: 0 = HI, 1 = LO
//   hilo_wd             mthi/mtlo write data
//   busy                high while iterating
//   done                one-cycle pulse when HI/LO take a new result
//   div_by_zero         last divide had b == 0; cleared by the next start
//   hi, lo              HI (upper product / remainder), LO (lower product / quotient)
module muldiv_seq #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mul0_div1_sel,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_we,
   input  logic             hi0_lo1_sel,
   input  logic [WIDTH-1:0] hilo_wd,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 accept;
   logic                 last;

   // Datapath state (not reset: always loaded on an accepted start).
   logic                 is_div;
   logic [WIDTH-1:0]     opnd;       // multiplicand for mul, divisor for div
   logic [2*WIDTH-1:0]   acc;        // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [WIDTH:0]       psum;
   logic [WIDTH:0]       shifted;
   logic [WIDTH+1:0]     diff;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;
   logic                 unused_bits;

   assign accept = start && (state != S_BUSY);
   assign last   = (state == S_BUSY) && (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    a_neg;
   logic                    b_neg;
   logic                    neg_q;   // negate product / quotient
   logic                    neg_r;   // negate remainder (dividend sign)

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + (2*WIDTH)'(1);
   endfunction

   assign a_s   = a;
   assign b_s   = b;
   assign a_neg = op_signed && (a_s < 0);
   assign b_neg = op_signed && (b_s < 0);
   // |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable as an unsigned magnitude.
   assign mag_a = a_neg ? neg_w(a) : a;
   assign mag_b = b_neg ? neg_w(b) : b;
   assign unused_bits = diff[WIDTH];
`else
   assign mag_a = a;
   assign mag_b = b;
   assign unused_bits = ^{diff[WIDTH], op_signed};
`endif

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      acc_nxt = acc;
      psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, opnd};
      if (is_div) begin
         if (!diff[WIDTH+1])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {psum, acc[WIDTH-1:1]};
      end
   end

   // Result as written on the final edge, with sign fixup when enabled.
   always_comb begin
      fix_hi = acc_nxt[2*WIDTH-1:WIDTH];
      fix_lo = acc_nxt[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
      if (is_div) begin
         if (neg_q) fix_lo = neg_w(acc_nxt[WIDTH-1:0]);
         if (neg_r) fix_hi = neg_w(acc_nxt[2*WIDTH-1:WIDTH]);
      end else if (neg_q) begin
         {fix_hi, fix_lo} = neg_2w(acc_nxt);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         is_div <= mul0_div1_sel;
         if (mul0_div1_sel) begin
            acc  <= {{WIDTH{1'b0}}, mag_a};
            opnd <= mag_b;
         end else begin
            acc  <= {{WIDTH{1'b0}}, mag_b};
            opnd <= mag_a;
         end
`ifdef MULDIV_SIGNED_EN
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
`endif
      end else if (state == S_BUSY) begin
         acc <= acc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               // mthi/mtlo first so a same-edge divide-by-zero result overrides it.
               if (hilo_we) begin
                  if (hi0_lo1_sel) lo <= hilo_wd;
                  else             hi <= hilo_wd;
               end
               if (start) begin
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  if (mul0_div1_sel && (b == '0)) begin
                     state       <= S_DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     div_by_zero <= 1'b1;
                     hi          <= a;
                     lo          <= '1;
                  end else begin
                     state <= S_BUSY;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_BUSY: begin
               if (last) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= fix_hi;
                  lo    <= fix_lo;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq - directed bench for muldiv_seq (WIDTH=32) with a result scoreboard.
// Expected {div_by_zero, hi, lo} is computed from 64-bit integer arithmetic when an
// operation is launched and compared when done is observed.
module tb_muldiv_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          mul0_div1_sel = 1'b0;
   logic          op_signed = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          hilo_we = 1'b0;
   logic          hi0_lo1_sel = 1'b0;
   logic [W-1:0]  hilo_wd = '0;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            total = 0;
   int            bad = 0;
   logic [64:0]   sb_q[$];
   logic [W-1:0]  hi_hold;
   logic [W-1:0]  lo_hold;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mul0_div1_sel(mul0_div1_sel),
      .op_signed(op_signed), .a(a), .b(b), .hilo_we(hilo_we),
      .hi0_lo1_sel(hi0_lo1_sel), .hilo_wd(hilo_wd), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {div_by_zero, hi, lo}.
   function automatic logic [64:0] model(input logic div, input logic sg,
                                         input logic [W-1:0] av, input logic [W-1:0] bv);
      longint sa, sb, p, q, r;
      logic   eff_sg;
`ifdef MULDIV_SIGNED_EN
      eff_sg = sg;
`else
      eff_sg = 1'b0;
`endif
      sa = eff_sg ? longint'($signed(av)) : longint'({32'h0, av});
      sb = eff_sg ? longint'($signed(bv)) : longint'({32'h0, bv});
      if (div && bv == '0) return {1'b1, av, 32'hFFFF_FFFF};
      if (!div) begin
         p = sa * sb;
         return {1'b0, p[63:0]};
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   // Called at a falling edge; returns one falling edge after the start edge E0.
   task automatic launch(input logic div, input logic sg, input logic [W-1:0] av, input logic [W-1:0] bv);
      mul0_div1_sel = div;
      op_signed     = sg;
      a             = av;
      b             = bv;
      start         = 1'b1;
      sb_q.push_back(model(div, sg, av, bv));
      @(negedge clk);
      start   = 1'b0;
      hilo_we = 1'b0;
   endtask

   // elapsed = falling edges already consumed after E0 by the caller.
   task automatic wait_done(input string tag, input int elapsed);
      int          lat;
      int          bcnt;
      int          exp_lat;
      logic [64:0] e;
      lat  = 0;
      bcnt = 0;
      e    = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else begin
         bad++;
         total++;
         $error("FAIL %s_queue observed=empty expected=entry", tag);
      end
      exp_lat = (e[64] ? 0 : W) - elapsed;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(e[64]));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // mthi / mtlo in IDLE
      hilo_we = 1'b1; hi0_lo1_sel = 1'b0; hilo_wd = 32'h0000_CAFE;
      @(negedge clk);
      hilo_we = 1'b0;
      check("mthi", 64'(hi), 64'h0000_CAFE);
      hilo_we = 1'b1; hi0_lo1_sel = 1'b1; hilo_wd = 32'h0000_BEEF;
      @(negedge clk);
      hilo_we = 1'b0;
      check("mtlo", 64'(lo), 64'h0000_BEEF);
      check("mtlo_hi_kept", 64'(hi), 64'h0000_CAFE);

      // multu max * max, then done is a single pulse
      launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_busy_e0", 64'(busy), 64'd1);
      check("multu_hi_stable", 64'(hi), 64'h0000_CAFE);
      wait_done("multu_max", 0);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // divu 100/7, then back-to-back launch from DONE
      launch(1'b1, 1'b0, 32'd100, 32'd7);
      wait_done("divu_100_7", 0);
      launch(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      check("b2b_busy", 64'(busy), 64'd1);
      wait_done("b2b_multu", 0);

      // op_signed=1 operations (signed or unsigned depending on build)
      launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7_2", 0);
      launch(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_done("mult_m3_5", 0);
      launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 0);
      launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      wait_done("div_m7_m2", 0);

      // divide by zero, then a multu clears the flag at its start edge
      launch(1'b1, 1'b0, 32'd5, 32'd0);
      wait_done("div0", 0);
      launch(1'b0, 1'b0, 32'd6, 32'd7);
      check("dbz_cleared_e0", 64'(div_by_zero), 64'd0);
      wait_done("after_div0", 0);

      // start + mtlo on the same edge: write lands first, result overwrites later
      @(negedge clk);
      hilo_we = 1'b1; hi0_lo1_sel = 1'b1; hilo_wd = 32'h0000_ABCD;
      launch(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0123);
      check("we_with_start_lo", 64'(lo), 64'h0000_ABCD);
      wait_done("we_with_start", 0);

      // start and mthi while BUSY are ignored
      hi_hold = hi;
      launch(1'b0, 1'b0, 32'h0001_0003, 32'h0000_0101);
      repeat (3) @(negedge clk);
      start = 1'b1; mul0_div1_sel = 1'b1; a = 32'd9; b = 32'd0;
      hilo_we = 1'b1; hi0_lo1_sel = 1'b0; hilo_wd = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0; hilo_we = 1'b0;
      check("busy_ignore_hi", 64'(hi), 64'(hi_hold));
      check("busy_ignore_busy", 64'(busy), 64'd1);
      wait_done("busy_ignore", 4);

      // asynchronous reset in the middle of an operation
      launch(1'b0, 1'b0, 32'h0F0F_0F0F, 32'h7777_7777);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      void'(sb_q.pop_back());
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("postrst_busy", 64'(busy), 64'd0);

      // a few random operations
      for (int i = 0; i < 6; i++) begin
         lo_hold = $urandom();
         launch(i[0], 1'($urandom_range(0, 1)), $urandom(), (i == 3) ? 32'd0 : lo_hold);
         wait_done("rand_op", 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
